mem_read_initiator: RTL and testbench

Read-side initiator for the main memory model. It accepts single-word read requests from the cache, aligns each one to an 8-byte line, and drives the memory `arvalid`/`addr` handshake. It waits for the one-cycle `rvalid` pulse, captures the 64-bit line and returns both the line and the requested 32-bit word. The block sits between the cache miss path and the main memory, and enforces the memory's timing rules:
- one-cycle request pulse;
- address held stable until `rvalid`;
- idle gap before the next request.

---
 rtl/mem_rd_pkg.sv | 15 +
 rtl/mem_rd_timer.sv | 31 +++
 rtl/mem_read_initiator.sv | 142 ++++++++++++++
 tb/tb_mem_read_initiator.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// Shared types and constants for the main-memory read initiator.
package mem_rd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } mem_rd_state_t;

   localparam int LINE_BYTES      = 8;
   localparam int MEM_NOMINAL_LAT = 9;
   localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_rd_timer.sv
// Saturating wait counter; expired flags the last allowed WAIT cycle.
module mem_rd_timer
   import mem_rd_pkg::*;
#(
   parameter int LIMIT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] count;

   // Holds at LIMIT so a stalled enable can never wrap back into range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != W'(LIMIT))) begin
         count <= count + W'(1);
      end
   end

   assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_read_initiator.sv
// Cache-side read initiator: aligns a word request to an 8-byte line, runs the
// one-shot arvalid/rvalid handshake with main memory and returns line plus word.
module mem_read_initiator
   import mem_rd_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 128,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              arvalid,
   output logic [ADDR_W-1:0] addr,
   input  logic [63:0]       data,
   input  logic              rvalid,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [63:0]       resp_line,
   output logic [31:0]       resp_word,
   output logic              resp_err
);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
   localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

   mem_rd_state_t state;
   mem_rd_state_t state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic              word_lo_q;
   logic [63:0]       resp_line_q;
   logic              resp_err_q;

   logic              addr_load;
   logic              resp_load;
   logic [63:0]       resp_line_nxt;
   logic              resp_err_nxt;
   logic              timer_clear;
   logic              timer_en;
   logic              timer_expired;
   logic              req_oor;

   assign req_oor = (req_addr >= MEM_LIMIT);

   mem_rd_timer #(
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Out-of-range requests skip memory entirely and answer with an error line.
   always_comb begin
      state_nxt     = state;
      addr_load     = 1'b0;
      resp_load     = 1'b0;
      resp_line_nxt = '0;
      resp_err_nxt  = 1'b0;
      timer_clear   = 1'b0;
      timer_en      = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               addr_load = 1'b1;
               if (req_oor) begin
                  resp_load    = 1'b1;
                  resp_err_nxt = 1'b1;
                  state_nxt    = RESP;
               end else begin
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            timer_clear = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            timer_en = 1'b1;
            if (rvalid) begin
               resp_load     = 1'b1;
               resp_line_nxt = data;
               state_nxt     = RESP;
            end else if (timer_expired) begin
               resp_load    = 1'b1;
               resp_err_nxt = 1'b1;
               state_nxt    = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         word_lo_q   <= 1'b0;
         resp_line_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         if (addr_load) begin
            addr_q    <= req_addr & LINE_MASK;
            word_lo_q <= req_addr[2];
         end
         if (resp_load) begin
            resp_line_q <= resp_line_nxt;
            resp_err_q  <= resp_err_nxt;
         end
      end
   end

   // Handshake outputs decode straight from state so reset drops them at once.
   assign req_ready  = (state == IDLE);
   assign arvalid    = (state == ISSUE);
   assign resp_valid = (state == RESP);
   assign addr       = addr_q;
   assign resp_line  = resp_line_q;
   assign resp_err   = resp_err_q;
   assign resp_word  = word_lo_q ? resp_line_q[31:0] : resp_line_q[63:32];

endmodule

// File: tb/tb_mem_read_initiator.sv
// Directed bench for mem_read_initiator with a 9-cycle memory model, mem[i]=i.
module tb_mem_read_initiator;
   import mem_rd_pkg::*;

   localparam int ADDR_W    = 32;
   localparam int MEM_BYTES = 128;
   localparam int TIMEOUT   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              arvalid;
   logic [ADDR_W-1:0] addr;
   logic [63:0]       data;
   logic              rvalid;
   logic              resp_valid;
   logic              resp_ready;
   logic [63:0]       resp_line;
   logic [31:0]       resp_word;
   logic              resp_err;

   logic [7:0]  mem [MEM_BYTES];
   logic        mem_enable;
   logic        mem_busy;
   int          mem_cnt;
   logic        mem_rvalid;
   logic        inj_rvalid;
   logic [63:0] mem_data;

   int   cyc          = 0;
   int   last_rv_cyc  = 0;
   int   last_arv_cyc = 0;
   int   arv_count    = 0;
   int   arv_double   = 0;
   logic prev_arv     = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   mem_read_initiator #(
      .ADDR_W    (ADDR_W),
      .MEM_BYTES (MEM_BYTES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .arvalid    (arvalid),
      .addr       (addr),
      .data       (data),
      .rvalid     (rvalid),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_line  (resp_line),
      .resp_word  (resp_word),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   assign rvalid = mem_rvalid | inj_rvalid;
   assign data   = mem_data;

   function automatic logic [63:0] line_of(input logic [ADDR_W-1:0] a);
      logic [63:0] l;
      l = '0;
      for (int b = 0; b < 8; b++) begin
         l[63-8*b -: 8] = mem[(int'(a) + b) % MEM_BYTES];
      end
      return l;
   endfunction

   // Memory model: latches the request on the arvalid edge, pulses rvalid 9 cycles later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_busy   <= 1'b0;
         mem_cnt    <= 0;
         mem_rvalid <= 1'b0;
      end else begin
         mem_rvalid <= 1'b0;
         if (arvalid && mem_enable) begin
            mem_busy <= 1'b1;
            mem_cnt  <= 1;
            mem_data <= line_of(addr);
         end else if (mem_busy) begin
            if (mem_cnt == MEM_NOMINAL_LAT - 1) begin
               mem_rvalid <= 1'b1;
               mem_busy   <= 1'b0;
            end else begin
               mem_cnt <= mem_cnt + 1;
            end
         end
      end
   end

   // Edge bookkeeping for handshake spacing and pulse width.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rvalid) last_rv_cyc = cyc;
      if (arvalid) begin
         last_arv_cyc = cyc;
         arv_count    = arv_count + 1;
         if (prev_arv) arv_double = arv_double + 1;
      end
      prev_arv = arvalid;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic issue_req(input logic [ADDR_W-1:0] a);
      req_addr  = a;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic accept_resp();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic serve_next(input logic [ADDR_W-1:0] a);
      resp_ready = 1'b1;
      req_addr   = a;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b0;
      inj_rvalid = 1'b0;
      mem_enable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_arvalid: got %b want 0", arvalid); end
      n_cmp++; if (addr !== 32'h0) begin n_err++; $display("[TB] FAIL reset_addr: got %h want 0", addr); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
      n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_resp_err: got %b want 0", resp_err); end
      n_cmp++; if (resp_line !== 64'h0) begin n_err++; $display("[TB] FAIL reset_resp_line: got %h want 0", resp_line); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_aligned_read();
      int lat;
      issue_req(32'h0C);
      n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("[TB] FAIL aligned_arvalid: got %b want 1", arvalid); end
      n_cmp++; if (addr !== 32'h08) begin n_err++; $display("[TB] FAIL aligned_addr: got %h want 08", addr); end
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("[TB] FAIL aligned_req_ready: got %b want 0", req_ready); end
      @(posedge clk); #1;
      n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("[TB] FAIL aligned_arvalid_drop: got %b want 0", arvalid); end
      n_cmp++; if (addr !== 32'h08) begin n_err++; $display("[TB] FAIL aligned_addr_hold: got %h want 08", addr); end
      wait_resp(lat);
      n_cmp++; if (lat !== 10) begin n_err++; $display("[TB] FAIL aligned_latency: got %0d want 10", lat); end
      n_cmp++; if (resp_line !== 64'h08090A0B0C0D0E0F) begin n_err++; $display("[TB] FAIL aligned_line: got %h want 08090a0b0c0d0e0f", resp_line); end
      n_cmp++; if (resp_word !== 32'h0C0D0E0F) begin n_err++; $display("[TB] FAIL aligned_word: got %h want 0c0d0e0f", resp_word); end
      n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("[TB] FAIL aligned_err: got %b want 0", resp_err); end
      accept_resp();
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL aligned_resp_one_cycle: got %b want 0", resp_valid); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("[TB] FAIL aligned_back_idle: got %b want 1", req_ready); end
   endtask

   task automatic test_word0();
      int lat;
      issue_req(32'h40);
      n_cmp++; if (addr !== 32'h40) begin n_err++; $display("[TB] FAIL word0_addr: got %h want 40", addr); end
      @(posedge clk); #1;
      wait_resp(lat);
      n_cmp++; if (lat !== 10) begin n_err++; $display("[TB] FAIL word0_latency: got %0d want 10", lat); end
      n_cmp++; if (resp_word !== 32'h40414243) begin n_err++; $display("[TB] FAIL word0_word: got %h want 40414243", resp_word); end
      n_cmp++; if (resp_line !== 64'h4041424344454647) begin n_err++; $display("[TB] FAIL word0_line: got %h want 4041424344454647", resp_line); end
      accept_resp();
   endtask

   task automatic test_out_of_range();
      int n0;
      n0 = arv_count;
      issue_req(32'h80);
      n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("[TB] FAIL oor_arvalid: got %b want 0", arvalid); end
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL oor_resp_valid: got %b want 1", resp_valid); end
      n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("[TB] FAIL oor_err: got %b want 1", resp_err); end
      n_cmp++; if (resp_line !== 64'h0) begin n_err++; $display("[TB] FAIL oor_line: got %h want 0", resp_line); end
      accept_resp();
      n_cmp++; if (arv_count !== n0) begin n_err++; $display("[TB] FAIL oor_no_access: got %0d want %0d", arv_count, n0); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("[TB] FAIL oor_back_idle: got %b want 1", req_ready); end
   endtask

   task automatic test_timeout();
      int lat;
      int n0;
      mem_enable = 1'b0;
      issue_req(32'h20);
      @(posedge clk); #1;
      wait_resp(lat);
      n_cmp++; if (lat !== 17) begin n_err++; $display("[TB] FAIL timeout_latency: got %0d want 17", lat); end
      n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("[TB] FAIL timeout_err: got %b want 1", resp_err); end
      n_cmp++; if (resp_line !== 64'h0) begin n_err++; $display("[TB] FAIL timeout_line: got %h want 0", resp_line); end
      accept_resp();
      mem_enable = 1'b1;
      n0 = arv_count;
      inj_rvalid = 1'b1;
      @(posedge clk); #1;
      inj_rvalid = 1'b0;
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL late_rvalid_resp: got %b want 0", resp_valid); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("[TB] FAIL late_rvalid_idle: got %b want 1", req_ready); end
      @(posedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL late_rvalid_resp2: got %b want 0", resp_valid); end
      n_cmp++; if (arv_count !== n0) begin n_err++; $display("[TB] FAIL late_rvalid_arvalid: got %0d want %0d", arv_count, n0); end
   endtask

   task automatic test_back_to_back();
      int lat;
      int rv0;
      issue_req(32'h00);
      n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_first_arvalid: got %b want 1", arvalid); end
      @(posedge clk); #1;
      wait_resp(lat);
      n_cmp++; if (lat !== 10) begin n_err++; $display("[TB] FAIL b2b_first_latency: got %0d want 10", lat); end
      rv0 = last_rv_cyc;
      repeat (5) begin @(posedge clk); #1; end
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_stall_valid: got %b want 1", resp_valid); end
      n_cmp++; if (resp_line !== 64'h0001020304050607) begin n_err++; $display("[TB] FAIL b2b_stall_line: got %h want 0001020304050607", resp_line); end
      serve_next(32'h78);
      n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_second_arvalid: got %b want 1", arvalid); end
      n_cmp++; if (addr !== 32'h78) begin n_err++; $display("[TB] FAIL b2b_second_addr: got %h want 78", addr); end
      @(posedge clk); #1;
      n_cmp++; if (last_arv_cyc - rv0 - 1 !== 7) begin n_err++; $display("[TB] FAIL b2b_stall_gap: got %0d want 7", last_arv_cyc - rv0 - 1); end
      n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_second_pulse: got %b want 0", arvalid); end
      wait_resp(lat);
      n_cmp++; if (lat !== 10) begin n_err++; $display("[TB] FAIL b2b_second_latency: got %0d want 10", lat); end
      n_cmp++; if (resp_line !== 64'h78797A7B7C7D7E7F) begin n_err++; $display("[TB] FAIL b2b_second_line: got %h want 78797a7b7c7d7e7f", resp_line); end
      rv0 = last_rv_cyc;
      serve_next(32'h04);
      n_cmp++; if (addr !== 32'h00) begin n_err++; $display("[TB] FAIL b2b_third_addr: got %h want 00", addr); end
      @(posedge clk); #1;
      n_cmp++; if (last_arv_cyc - rv0 - 1 !== 2) begin n_err++; $display("[TB] FAIL b2b_min_gap: got %0d want 2", last_arv_cyc - rv0 - 1); end
      wait_resp(lat);
      n_cmp++; if (resp_word !== 32'h04050607) begin n_err++; $display("[TB] FAIL b2b_third_word: got %h want 04050607", resp_word); end
      accept_resp();
   endtask

   task automatic test_reset_in_wait();
      int lat;
      issue_req(32'h28);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #4;
      n_cmp++; if (addr !== 32'h28) begin n_err++; $display("[TB] FAIL rstwait_addr_before: got %h want 28", addr); end
      #1;
      rst = 1'b1;
      #1;
      n_cmp++; if (addr !== 32'h0) begin n_err++; $display("[TB] FAIL rstwait_addr: got %h want 0", addr); end
      n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("[TB] FAIL rstwait_arvalid: got %b want 0", arvalid); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstwait_resp_valid: got %b want 0", resp_valid); end
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rstwait_req_ready: got %b want 1", req_ready); end
      issue_req(32'h10);
      n_cmp++; if (addr !== 32'h10) begin n_err++; $display("[TB] FAIL rstwait_new_addr: got %h want 10", addr); end
      @(posedge clk); #1;
      wait_resp(lat);
      n_cmp++; if (lat !== 10) begin n_err++; $display("[TB] FAIL rstwait_latency: got %0d want 10", lat); end
      n_cmp++; if (resp_line !== 64'h1011121314151617) begin n_err++; $display("[TB] FAIL rstwait_line: got %h want 1011121314151617", resp_line); end
      n_cmp++; if (resp_word !== 32'h10111213) begin n_err++; $display("[TB] FAIL rstwait_word: got %h want 10111213", resp_word); end
      accept_resp();
   endtask

   task automatic test_pulse_rules();
      n_cmp++; if (arv_double !== 0) begin n_err++; $display("[TB] FAIL arvalid_consecutive: got %0d want 0", arv_double); end
      n_cmp++; if (arv_count !== 8) begin n_err++; $display("[TB] FAIL arvalid_total: got %0d want 8", arv_count); end
   endtask

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i);
      test_reset();
      test_aligned_read();
      test_word0();
      test_out_of_range();
      test_timeout();
      test_back_to_back();
      test_reset_in_wait();
      test_pulse_rules();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
